// File: rtl/fetch_pkg.sv
// Shared types for the fetch front end.
// Queue entry layout, FSM states and reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DROP
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;
  localparam logic [3:0]  RMASK_WORD       = 4'b1111;

  function automatic logic [31:0] pc_next(
    input logic [31:0] pc
  );
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Fetch stage: owns the PC, one outstanding icache read,
// pushes {pc, instr} into the instruction queue.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter int          ENTRY_WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic [31:0]            imem_addr,
  output logic [3:0]             imem_rmask,
  input  logic [31:0]            imem_rdata,
  input  logic                   imem_resp,
  output logic [ENTRY_WIDTH-1:0] iq_wdata,
  output logic                   iq_enqueue,
  input  logic                   iq_full,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic [31:0]  hold_data, hold_n;
  fetch_entry_t entry;

  assign iq_wdata = entry;

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= REQ;
      pc        <= RESET_PC;
      hold_data <= '0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      hold_data <= hold_n;
    end
  end

  // Next state and outputs; redirect overrides every state.
  always_comb begin
    state_n    = state;
    pc_n       = pc;
    hold_n     = hold_data;
    imem_addr  = pc;
    imem_rmask = '0;
    iq_enqueue = 1'b0;
    entry      = '0;
    if (!rst) begin
      state_n = REQ;
      pc_n    = RESET_PC;
      hold_n  = '0;
    end else if (redirect_valid) begin
      pc_n   = redirect_pc & ~32'd3;
      hold_n = '0;
      if ((state == WAIT || state == DROP)
          && !imem_resp)
        state_n = DROP;
      else
        state_n = REQ;
    end else begin
      unique case (state)
        REQ: begin
          imem_rmask = RMASK_WORD;
          state_n    = WAIT;
        end
        WAIT: begin
          if (imem_resp && !iq_full) begin
            iq_enqueue  = 1'b1;
            entry.pc    = pc;
            entry.instr = imem_rdata;
            pc_n        = pc_next(pc);
            imem_addr   = pc_next(pc);
            imem_rmask  = RMASK_WORD;
          end else if (imem_resp) begin
            hold_n  = imem_rdata;
            state_n = HOLD;
          end
        end
        HOLD: begin
          if (!iq_full) begin
            iq_enqueue  = 1'b1;
            entry.pc    = pc;
            entry.instr = hold_data;
            pc_n        = pc_next(pc);
            imem_addr   = pc_next(pc);
            imem_rmask  = RMASK_WORD;
            state_n     = WAIT;
          end
        end
        DROP: begin
          if (imem_resp) begin
            imem_rmask = RMASK_WORD;
            state_n    = WAIT;
          end
        end
        default: state_n = REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed plan steps then random
// traffic against a transaction-level cache/queue model.
module tb_fetch_stage;

  localparam logic [31:0] RPC = 32'h1eceb000;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [63:0] iq_wdata;
  logic        iq_enqueue;
  logic        iq_full;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  int vectors;
  int miscompares;
  int n_enq;

  // cache model: one outstanding request
  bit          c_valid;
  bit          c_stale;
  int          c_cnt;
  logic [31:0] c_addr;
  logic [31:0] c_data;
  int          lat_cfg;
  bit          use_fix;
  logic [31:0] data_fix;

  // program-order model
  logic [31:0] exp_fetch;
  logic [63:0] expq[$];

  fetch_stage dut (
    .clk           (clk),
    .rst           (rst),
    .imem_addr     (imem_addr),
    .imem_rmask    (imem_rmask),
    .imem_rdata    (imem_rdata),
    .imem_resp     (imem_resp),
    .iq_wdata      (iq_wdata),
    .iq_enqueue    (iq_enqueue),
    .iq_full       (iq_full),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [63:0] obs,
    input logic [63:0] exp
  );
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic        full,
    input logic        rv,
    input logic [31:0] rpc,
    input logic        rs
  );
    logic        resp;
    logic [63:0] ent;
    @(posedge clk);
    #1;
    if (c_valid) c_cnt--;
    resp = rs && c_valid && (c_cnt <= 0);
    rst            = rs;
    imem_resp      = resp;
    imem_rdata     = resp ? c_data : $urandom;
    iq_full        = full;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #3;
    if (!rs) begin
      chk("rst_rmask", 64'(imem_rmask), 0);
      chk("rst_enq", 64'(iq_enqueue), 0);
      chk("rst_wdata", iq_wdata, 0);
      c_valid   = 0;
      expq.delete();
      exp_fetch = RPC;
      return;
    end
    if (full) chk("enq_while_full", 64'(iq_enqueue), 0);
    if (rv) begin
      chk("redir_rmask", 64'(imem_rmask), 0);
      chk("redir_enq", 64'(iq_enqueue), 0);
      if (resp) c_valid = 0;
      else c_stale = 1;
      expq.delete();
      exp_fetch = rpc & ~32'd3;
      return;
    end
    if (resp) begin
      c_valid = 0;
      if (!c_stale) expq.push_back({c_addr, c_data});
    end
    chk("enq_due", 64'(iq_enqueue),
        64'(!full && expq.size() > 0));
    if (iq_enqueue === 1'b1 && expq.size() > 0) begin
      ent = expq.pop_front();
      chk("enq_data", iq_wdata, ent);
      n_enq++;
    end
    chk("rmask_val",
        64'(imem_rmask == 4'h0 || imem_rmask == 4'hf), 1);
    if (imem_rmask == 4'hf) begin
      chk("one_outstanding", 64'(c_valid), 0);
      chk("req_addr", 64'(imem_addr), 64'(exp_fetch));
      c_addr    = exp_fetch;
      exp_fetch = exp_fetch + 32'd4;
      c_valid   = 1;
      c_stale   = 0;
      c_cnt     = lat_cfg > 0 ? lat_cfg
                              : $urandom_range(1, 3);
      c_data    = use_fix ? data_fix : $urandom;
    end
  endtask

  task automatic go(input logic full = 0);
    step(full, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic redir(input logic [31:0] rpc);
    step(1'b0, 1'b1, rpc, 1'b1);
  endtask

  initial begin
    vectors        = 0;
    miscompares    = 0;
    n_enq          = 0;
    c_valid        = 0;
    c_stale        = 0;
    c_cnt          = 0;
    c_addr         = '0;
    c_data         = '0;
    exp_fetch      = RPC;
    rst            = 1'b0;
    imem_rdata     = '0;
    imem_resp      = 1'b0;
    iq_full        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    lat_cfg        = 1;
    use_fix        = 1;
    data_fix       = 32'h00000013;

    // reset for two cycles
    step(1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 1'b0);
    // first cycle out of reset
    go();
    chk("first_rmask", 64'(imem_rmask), 64'hf);
    chk("first_addr", 64'(imem_addr), 64'h1eceb000);
    // streaming
    go();
    chk("s0_enq", 64'(iq_enqueue), 1);
    chk("s0_wdata", iq_wdata, 64'h1eceb000_00000013);
    go();
    chk("s1_wdata", iq_wdata, 64'h1eceb004_00000013);
    go();
    chk("s2_wdata", iq_wdata, 64'h1eceb008_00000013);
    // back-pressure on response for 0x1eceb010
    data_fix = 32'hcafebabe;
    go();
    chk("s3_addr", 64'(imem_addr), 64'h1eceb010);
    repeat (3) begin
      go(1'b1);
      chk("bp_enq", 64'(iq_enqueue), 0);
      chk("bp_rmask", 64'(imem_rmask), 0);
    end
    go();
    chk("bp_rel_enq", 64'(iq_enqueue), 1);
    chk("bp_rel_wdata", iq_wdata, 64'h1eceb010_cafebabe);
    chk("bp_rel_rmask", 64'(imem_rmask), 64'hf);
    chk("bp_rel_addr", 64'(imem_addr), 64'h1eceb014);
    // redirect with a request outstanding
    go();
    go();
    lat_cfg = 3;
    go();
    chk("req20_addr", 64'(imem_addr), 64'h1eceb020);
    redir(32'h1eceb102);
    go();
    chk("drop_idle_rmask", 64'(imem_rmask), 0);
    lat_cfg  = 1;
    data_fix = 32'h11111111;
    go();
    chk("drop_enq", 64'(iq_enqueue), 0);
    chk("drop_rmask", 64'(imem_rmask), 64'hf);
    chk("drop_addr", 64'(imem_addr), 64'h1eceb100);
    go();
    chk("redir_wdata", iq_wdata, 64'h1eceb100_11111111);
    // redirect coincident with a response
    redir(32'h1eceb200);
    chk("coinc_enq", 64'(iq_enqueue), 0);
    data_fix = 32'h22222222;
    go();
    chk("coinc_rmask", 64'(imem_rmask), 64'hf);
    chk("coinc_addr", 64'(imem_addr), 64'h1eceb200);
    data_fix = 32'h33333333;
    go();
    chk("coinc_wdata", iq_wdata, 64'h1eceb200_22222222);
    // redirect while holding
    go(1'b1);
    chk("hold_enq", 64'(iq_enqueue), 0);
    redir(32'h1eceb300);
    chk("hold_redir_enq", 64'(iq_enqueue), 0);
    go();
    chk("hold_new_addr", 64'(imem_addr), 64'h1eceb300);
    // wrap
    data_fix = 32'h44444444;
    redir(32'hfffffffc);
    go();
    chk("wrap_req", 64'(imem_addr), 64'hfffffffc);
    lat_cfg = 3;
    go();
    chk("wrap_wdata", iq_wdata, 64'hfffffffc_44444444);
    chk("wrap_addr", 64'(imem_addr), 64'h0);
    chk("wrap_rmask", 64'(imem_rmask), 64'hf);
    // reset while waiting
    step(1'b0, 1'b0, 32'h0, 1'b0);
    go();
    chk("rst_mid_addr", 64'(imem_addr), 64'(RPC));
    chk("rst_mid_rmask", 64'(imem_rmask), 64'hf);

    // random traffic
    use_fix = 0;
    lat_cfg = 0;
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rp;
      rp = ($urandom_range(0, 3) == 0)
             ? 32'hfffffff0 + $urandom_range(0, 15)
             : $urandom;
      step($urandom_range(0, 9) < 3,
           $urandom_range(0, 19) == 0,
           rp,
           $urandom_range(0, 99) != 0);
    end
    repeat (12) go();
    chk("drain", 64'(expq.size()), 0);
    chk("progress", 64'(n_enq > 200), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
